// File: rtl/prog_loader.sv
// Instruction-cache loader: collects a 3-byte word-count header and little-endian
// 32-bit words from a byte stream, writes them from address 0 upward, then raises start.
module prog_loader #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [31:0]       i_instruction,
    output logic [ADDR_W-1:0] i_addr,
    output logic              i_wea,
    output logic              start,
    output logic              load_err,
    output logic [ADDR_W-1:0] words_loaded
);

    typedef enum logic [1:0] {HDR, LOAD, RUN, ERR} state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       count_q;
    logic [23:0]       asm_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] words_q;
    logic              wea_q;
    logic              start_q;
    logic              err_q;

    logic              accept;
    logic [23:0]       hdr_full;
    logic [31:0]       word_full;
    logic              last_word;

    assign rx_ready  = (state_q == HDR) || (state_q == LOAD);
    assign accept    = rx_valid & rx_ready & ~reload;
    assign hdr_full  = {rx_data, count_q[15:0]};
    assign word_full = {rx_data, asm_q};
    // The pulse being retired is the final one once words_loaded reaches count.
    assign last_word = (24'(words_q) + 24'd1) == count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HDR;
            byte_cnt_q <= 2'd0;
            count_q    <= 24'd0;
            asm_q      <= 24'd0;
            instr_q    <= 32'd0;
            addr_q     <= '0;
            words_q    <= '0;
            wea_q      <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
        end else if (reload) begin
            // Address and data are left as-is; nothing is written while wea is low.
            state_q    <= HDR;
            byte_cnt_q <= 2'd0;
            count_q    <= 24'd0;
            words_q    <= '0;
            wea_q      <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (wea_q) begin
                wea_q   <= 1'b0;
                words_q <= words_q + ADDR_W'(1);
                if (last_word) begin
                    state_q <= RUN;
                    start_q <= 1'b1;
                end
            end
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (state_q)
                    HDR: begin
                        case (byte_cnt_q)
                            2'd0: count_q[7:0]  <= rx_data;
                            2'd1: count_q[15:8] <= rx_data;
                            default: begin
                                count_q[23:16] <= rx_data;
                                byte_cnt_q     <= 2'd0;
                                if (hdr_full == 24'd0) begin
                                    state_q <= RUN;
                                    start_q <= 1'b1;
                                end else if (hdr_full > 24'(DEPTH)) begin
                                    state_q <= ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= LOAD;
                                end
                            end
                        endcase
                    end
                    LOAD: begin
                        case (byte_cnt_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                instr_q <= word_full;
                                addr_q  <= words_q;
                                wea_q   <= 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i_instruction = instr_q;
    assign i_addr        = addr_q;
    assign i_wea         = wea_q;
    assign start         = start_q;
    assign load_err      = err_q;
    assign words_loaded  = words_q;

endmodule
